// File: rtl/user_sample_core.sv
// -----------------------------------------------------------------------------
// user_sample_core
//
// Counts time tags per input channel over a programmable time window. Tags
// arrive WORD_WIDTH lanes per beat on an AXI-Stream-style interface. Each
// counted lane adds 1 to a saturating 32-bit per-channel accumulator. When a
// beat's lowest time bound reaches the current window end, the accumulators
// are latched into RESULT, the window counter advances and the accumulators
// restart with that beat's own counts. Results are read over a Wishbone
// classic slave and summarised on LEDs (led[i] = RESULT[i] != 0).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_tvalid / s_tready   beat handshake (ready whenever out of reset)
//   s_tkeep               per-lane tag valid
//   s_tagtime             per-lane tag time (carried but not needed here)
//   s_channel             per-lane channel number
//   s_lowest_time_bound   lower bound of all tag times in the beat
//   wb_*                  Wishbone classic register slave, 8-bit byte address
//   led                   per-channel activity indicators
// -----------------------------------------------------------------------------
module user_sample_core #(
    parameter int WORD_WIDTH    = 2,
    parameter int CHANNELS      = 4,
    parameter int TIME_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_tvalid,
    output logic                              s_tready,
    input  logic [WORD_WIDTH-1:0]             s_tkeep,
    input  logic [WORD_WIDTH*TIME_WIDTH-1:0]  s_tagtime,
    input  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] s_channel,
    input  logic [TIME_WIDTH-1:0]             s_lowest_time_bound,
    input  logic [7:0]                        wb_adr_i,
    input  logic [31:0]                       wb_dat_i,
    input  logic [3:0]                        wb_sel_i,
    input  logic                              wb_we_i,
    input  logic                              wb_stb_i,
    input  logic                              wb_cyc_i,
    output logic [31:0]                       wb_dat_o,
    output logic                              wb_ack_o,
    output logic [CHANNELS-1:0]               led
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);

    localparam logic [31:0]           ID_VALUE     = 32'h5553_4D50;
    localparam logic [TIME_WIDTH-1:0] WINDOW_RESET = TIME_WIDTH'(1_000_000);

    localparam logic [7:0] ADR_ID      = 8'h00;
    localparam logic [7:0] ADR_CONTROL = 8'h04;
    localparam logic [7:0] ADR_WIN_LO  = 8'h08;
    localparam logic [7:0] ADR_WIN_HI  = 8'h0C;
    localparam logic [7:0] ADR_COUNT   = 8'h10;
    localparam logic [7:0] ADR_STATUS  = 8'h14;
    localparam logic [7:0] ADR_RESULT  = 8'h20;

    logic                             enable_q, enable_d;
    logic                             anchored_q, anchored_d;
    logic                             valid_q, valid_d;
    logic [TIME_WIDTH-1:0]            window_q, window_d;
    logic [TIME_WIDTH-1:0]            window_end_q, window_end_d;
    logic [31:0]                      count_q, count_d;
    logic [CHANNELS-1:0][31:0]        acc_q, acc_d;
    logic [CHANNELS-1:0][31:0]        result_q, result_d;
    logic [CHANNELS-1:0]              led_q, led_d;
    logic                             ack_q;
    logic [31:0]                      dat_q, rdata;

    logic [CHANNELS-1:0][CNT_W-1:0]   beat_cnt;
    logic                             wb_req, wb_wr, clear, beat, crossing;
    logic [TIME_WIDTH-1:0]            next_end;

    // The tag times themselves are not needed; the beat bound decides windows.
    logic unused_inputs;
    assign unused_inputs = ^{s_tagtime, wb_sel_i};

    assign s_tready = rst_n;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign led      = led_q;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CNT_W-1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(b);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Per-channel hit count of the current beat; out-of-range channels match nothing.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            beat_cnt[c] = '0;
            for (int k = 0; k < WORD_WIDTH; k++) begin
                if (s_tkeep[k] && s_channel[k*CHANNEL_WIDTH +: CHANNEL_WIDTH] == CHANNEL_WIDTH'(c)) begin
                    beat_cnt[c] = beat_cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    // A new request is only taken when no ack is in flight: one transfer per two cycles.
    assign wb_req   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wb_wr    = wb_req & wb_we_i;
    assign clear    = wb_wr & (wb_adr_i == ADR_CONTROL) & wb_dat_i[1];
    assign beat     = s_tvalid & s_tready & enable_q;
    assign crossing = beat & anchored_q & (s_lowest_time_bound >= window_end_q);
    assign next_end = window_end_q + window_q;

    // NOTE: every output of this block gets a default before any condition,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        enable_d     = enable_q;
        anchored_d   = anchored_q;
        valid_d      = valid_q;
        window_d     = window_q;
        window_end_d = window_end_q;
        count_d      = count_q;
        acc_d        = acc_q;
        result_d     = result_q;

        if (wb_wr) begin
            case (wb_adr_i)
                ADR_CONTROL: begin
                    enable_d = wb_dat_i[0];
                    // Re-anchor on the first beat after a fresh enable.
                    if (wb_dat_i[0] && !enable_q) anchored_d = 1'b0;
                end
                ADR_WIN_LO: window_d[31:0]  = wb_dat_i;
                ADR_WIN_HI: window_d[63:32] = wb_dat_i;
                default: ;
            endcase
        end

        if (beat) begin
            if (!anchored_q) begin
                anchored_d   = 1'b1;
                window_end_d = s_lowest_time_bound + window_q;
                for (int c = 0; c < CHANNELS; c++) acc_d[c] = sat_add(acc_q[c], beat_cnt[c]);
            end else if (crossing) begin
                result_d = acc_q;
                for (int c = 0; c < CHANNELS; c++) acc_d[c] = 32'(beat_cnt[c]);
                count_d  = count_q + 32'd1;
                valid_d  = 1'b1;
                // Skipped windows are not reported: jump straight past the bound.
                window_end_d = (next_end <= s_lowest_time_bound) ? s_lowest_time_bound + window_q
                                                                 : next_end;
            end else begin
                for (int c = 0; c < CHANNELS; c++) acc_d[c] = sat_add(acc_q[c], beat_cnt[c]);
            end
        end

        // Clear has priority over a crossing in the same cycle.
        if (clear) begin
            anchored_d = 1'b0;
            valid_d    = 1'b0;
            count_d    = '0;
            acc_d      = '0;
            result_d   = '0;
        end
    end

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            ADR_ID:      rdata = ID_VALUE;
            ADR_CONTROL: rdata = {31'd0, enable_q};
            ADR_WIN_LO:  rdata = window_q[31:0];
            ADR_WIN_HI:  rdata = window_q[63:32];
            ADR_COUNT:   rdata = count_q;
            ADR_STATUS:  rdata = {31'd0, valid_q};
            default: ;
        endcase
        for (int i = 0; i < CHANNELS; i++) begin
            if (wb_adr_i == ADR_RESULT + 8'(4*i)) rdata = result_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) led_d[i] = (result_q[i] != 32'd0);
    end

    // NOTE: the accumulator and result arrays are plain flops, not RAM, and
    // must read back as zero after reset, so they are reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q     <= 1'b0;
            anchored_q   <= 1'b0;
            valid_q      <= 1'b0;
            window_q     <= WINDOW_RESET;
            window_end_q <= '0;
            count_q      <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            led_q        <= '0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            enable_q     <= enable_d;
            anchored_q   <= anchored_d;
            valid_q      <= valid_d;
            window_q     <= window_d;
            window_end_q <= window_end_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            led_q        <= led_d;
            ack_q        <= wb_req;
            dat_q        <= wb_req ? rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_user_sample_core.sv
// -----------------------------------------------------------------------------
// tb_user_sample_core
//
// Self-checking bench for user_sample_core. A behavioural model keeps the
// per-channel counts, results and window bookkeeping as plain variables and is
// updated beat-by-beat and write-by-write; register reads and LEDs are compared
// against it. Directed scenarios cover the main window rules, then a random
// stream exercises mixed beats, window writes, clears and enable toggles.
// -----------------------------------------------------------------------------
module tb_user_sample_core;

    localparam int WW = 2;
    localparam int CH = 4;
    localparam int TW = 64;
    localparam int CW = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [WW-1:0]     s_tkeep = '0;
    logic [WW*TW-1:0]  s_tagtime = '0;
    logic [WW*CW-1:0]  s_channel = '0;
    logic [TW-1:0]     s_lowest_time_bound = '0;
    logic [7:0]        wb_adr_i = '0;
    logic [31:0]       wb_dat_i = '0;
    logic [3:0]        wb_sel_i = 4'hF;
    logic              wb_we_i = 1'b0;
    logic              wb_stb_i = 1'b0;
    logic              wb_cyc_i = 1'b0;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic [CH-1:0]     led;

    user_sample_core #(
        .WORD_WIDTH(WW), .CHANNELS(CH), .TIME_WIDTH(TW), .CHANNEL_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tkeep(s_tkeep),
        .s_tagtime(s_tagtime), .s_channel(s_channel),
        .s_lowest_time_bound(s_lowest_time_bound),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .led(led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_acc [CH];
    logic [31:0] m_res [CH];
    logic [31:0] m_count;
    bit          m_valid, m_anch, m_en;
    logic [63:0] m_end, m_win;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin m_acc[c] = '0; m_res[c] = '0; end
        m_count = '0; m_valid = 0; m_anch = 0; m_en = 0;
        m_end = '0; m_win = 64'd1_000_000;
    endfunction

    function automatic void add_counts(input int cnt[CH]);
        for (int c = 0; c < CH; c++) begin
            longint unsigned s;
            s = longint'(m_acc[c]) + longint'(cnt[c]);
            m_acc[c] = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
        end
    endfunction

    function automatic void model_beat(input logic [1:0] keep, input int c0, input int c1,
                                       input logic [63:0] bound);
        int cnt[CH];
        int lane_ch[2];
        lane_ch[0] = c0; lane_ch[1] = c1;
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        for (int k = 0; k < 2; k++)
            if (keep[k] && lane_ch[k] < CH) cnt[lane_ch[k]]++;
        if (!m_en) return;
        if (!m_anch) begin
            m_anch = 1;
            m_end  = bound + m_win;
            add_counts(cnt);
        end else if (bound >= m_end) begin
            for (int c = 0; c < CH; c++) begin m_res[c] = m_acc[c]; m_acc[c] = 32'(cnt[c]); end
            m_count = m_count + 1;
            m_valid = 1;
            m_end   = m_end + m_win;
            if (m_end <= bound) m_end = bound + m_win;
        end else begin
            add_counts(cnt);
        end
    endfunction

    function automatic void model_write(input logic [7:0] adr, input logic [31:0] d);
        case (adr)
            8'h04: begin
                if (d[0] && !m_en) m_anch = 0;
                m_en = d[0];
                if (d[1]) begin
                    for (int c = 0; c < CH; c++) begin m_acc[c] = '0; m_res[c] = '0; end
                    m_count = '0; m_valid = 0; m_anch = 0;
                end
            end
            8'h08: m_win[31:0]  = d;
            8'h0C: m_win[63:32] = d;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] adr);
        case (adr)
            8'h00: return 32'h5553_4D50;
            8'h04: return {31'd0, m_en};
            8'h08: return m_win[31:0];
            8'h0C: return m_win[63:32];
            8'h10: return m_count;
            8'h14: return {31'd0, m_valid};
            8'h20: return m_res[0];
            8'h24: return m_res[1];
            8'h28: return m_res[2];
            8'h2C: return m_res[3];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [CH-1:0] model_led();
        logic [CH-1:0] l;
        for (int c = 0; c < CH; c++) l[c] = (m_res[c] != 0);
        return l;
    endfunction

    // ---------------- bus / stream drivers (called at a negedge) ----------------
    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
        bit acked;
        acked = 0;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdata;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_ack_o) begin acked = 1; break; end
        end
        rdata = wb_dat_o;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        if (!acked) check("wb_ack_timeout", 64'(acked), 64'd1);
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] d);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, adr, d, unused_rd);
        model_write(adr, d);
    endtask

    task automatic read_check(input string tag, input logic [7:0] adr);
        logic [31:0] rd;
        wb_xfer(1'b0, adr, 32'd0, rd);
        check(tag, 64'(rd), 64'(model_read(adr)));
    endtask

    task automatic read_expect(input string tag, input logic [7:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, adr, 32'd0, rd);
        check(tag, 64'(rd), 64'(exp));
    endtask

    task automatic check_all(input string tag);
        logic [7:0] adrs [12];
        adrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'hFC};
        foreach (adrs[i]) read_check($sformatf("%s_reg%02h", tag, adrs[i]), adrs[i]);
        check({tag, "_led"}, 64'(led), 64'(model_led()));
    endtask

    task automatic send_beat(input logic [1:0] keep, input int c0, input int c1, input logic [63:0] bound);
        s_tvalid = 1; s_tkeep = keep;
        s_channel = {CW'(c1), CW'(c0)};
        s_lowest_time_bound = bound;
        s_tagtime = {bound + 64'd7, bound + 64'd3};
        @(negedge clk);
        s_tvalid = 0;
        model_beat(keep, c0, c1, bound);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] t;
        logic [31:0] rd;
        model_reset();

        // ---- reset values ----
        #1;
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_led", 64'(led), 64'd0);
        check("rst_ack", 64'(wb_ack_o), 64'd0);
        check("rst_dat", 64'(wb_dat_o), 64'd0);
        #21 rst_n = 1;
        @(negedge clk);
        check("tready_out_of_reset", 64'(s_tready), 64'd1);

        // ---- ack pulses 1-0-1 while the request is held ----
        wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = 8'h00;
        @(negedge clk);
        check("ack_first", 64'(wb_ack_o), 64'd1);
        check("id_first", 64'(wb_dat_o), 64'h5553_4D50);
        @(negedge clk);
        check("ack_gap", 64'(wb_ack_o), 64'd0);
        @(negedge clk);
        check("ack_second", 64'(wb_ack_o), 64'd1);
        wb_cyc_i = 0; wb_stb_i = 0;
        @(negedge clk);

        read_expect("id", 8'h00, 32'h5553_4D50);
        read_expect("window_reset", 8'h08, 32'd1_000_000);
        read_expect("control_reset", 8'h04, 32'd0);
        check_all("reset");

        // ---- basic window on channel 1 ----
        wb_write(8'h08, 32'd100_000);
        wb_write(8'h0C, 32'd0);
        wb_write(8'h04, 32'd1);
        send_beat(2'b01, 1, 0, 64'd0);
        send_beat(2'b01, 1, 0, 64'd10_000);
        send_beat(2'b01, 1, 0, 64'd20_000);
        send_beat(2'b01, 1, 0, 64'd30_000);
        send_beat(2'b00, 0, 0, 64'd100_000);
        read_expect("basic_result1", 8'h24, 32'd4);
        read_expect("basic_count", 8'h10, 32'd1);
        read_expect("basic_status", 8'h14, 32'd1);
        check("basic_led", 64'(led), 64'b0010);
        check_all("basic");

        // ---- both lanes on one channel, then one lane ----
        send_beat(2'b11, 2, 2, 64'd150_000);
        send_beat(2'b00, 0, 0, 64'd200_000);
        read_expect("two_lanes_result2", 8'h28, 32'd2);
        send_beat(2'b01, 2, 2, 64'd250_000);
        send_beat(2'b00, 0, 0, 64'd300_000);
        read_expect("one_lane_result2", 8'h28, 32'd1);
        check_all("lanes");

        // ---- out-of-range channel and disabled-state tags ----
        send_beat(2'b11, 5, 5, 64'd310_000);
        send_beat(2'b00, 0, 0, 64'd400_000);
        check_all("ch5");
        wb_write(8'h04, 32'd0);
        send_beat(2'b11, 0, 0, 64'd410_000);
        wb_write(8'h04, 32'd1);
        send_beat(2'b00, 0, 0, 64'd420_000);
        send_beat(2'b00, 0, 0, 64'd520_000);
        read_expect("disabled_result0", 8'h20, 32'd0);
        read_expect("disabled_count", 8'h10, 32'd5);
        check_all("disabled");

        // ---- bound jump reports exactly one window ----
        wb_write(8'h04, 32'd3);
        send_beat(2'b01, 3, 0, 64'd50_000);
        send_beat(2'b00, 0, 0, 64'd450_000);
        read_expect("jump_count", 8'h10, 32'd1);
        read_expect("jump_result3", 8'h2C, 32'd1);
        send_beat(2'b00, 0, 0, 64'd549_999);
        read_expect("jump_before_end", 8'h10, 32'd1);
        send_beat(2'b00, 0, 0, 64'd550_000);
        read_expect("jump_at_end", 8'h10, 32'd2);

        // ---- clear on the same cycle as a crossing: clear wins ----
        send_beat(2'b11, 0, 1, 64'd600_000);
        s_tvalid = 1; s_tkeep = 2'b01; s_channel = {CW'(0), CW'(2)};
        s_lowest_time_bound = 64'd650_000;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 8'h04; wb_dat_i = 32'd3;
        @(negedge clk);
        check("clear_cross_ack", 64'(wb_ack_o), 64'd1);
        s_tvalid = 0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        model_beat(2'b01, 2, 0, 64'd650_000);
        model_write(8'h04, 32'd3);
        read_expect("clear_cross_count", 8'h10, 32'd0);
        read_expect("clear_cross_result0", 8'h20, 32'd0);
        read_expect("clear_cross_status", 8'h14, 32'd0);
        send_beat(2'b01, 0, 0, 64'd700_000);
        send_beat(2'b00, 0, 0, 64'd799_999);
        read_expect("reanchor_no_cross", 8'h10, 32'd0);
        send_beat(2'b00, 0, 0, 64'd800_000);
        read_expect("reanchor_result0", 8'h20, 32'd1);
        check_all("clear_cross");

        // ---- randomized stream ----
        t = 64'd1_000_000;
        for (int op = 0; op < 240; op++) begin
            int sel;
            sel = int'($urandom_range(0, 11));
            if (sel < 8) begin
                if ($urandom_range(0, 11) == 0) t = t + 64'(500_000);
                else t = t + 64'($urandom_range(0, 40_000));
                send_beat(2'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), t);
            end else if (sel == 8) begin
                wb_write(8'h08, 32'($urandom_range(20_000, 150_000)));
            end else if (sel == 9) begin
                wb_write(8'h04, ($urandom_range(0, 3) == 0) ? 32'd3 : 32'd1);
            end else if (sel == 10) begin
                wb_write(8'h04, {31'd0, 1'($urandom_range(0, 1))});
            end else begin
                wb_write(8'h10, $urandom());
            end
            if (op % 20 == 19) check_all($sformatf("rand%0d", op));
        end
        wb_write(8'h04, 32'd1);
        check_all("rand_end");

        // ---- clear during a stream ----
        wb_write(8'h08, 32'd50_000);
        wb_write(8'h0C, 32'd0);
        t = t + 64'd1_000_000;
        send_beat(2'b11, 0, 3, t);
        send_beat(2'b11, 1, 3, t + 64'd10_000);
        send_beat(2'b01, 2, 0, t + 64'd60_000);
        send_beat(2'b01, 2, 0, t + 64'd70_000);
        wb_write(8'h04, 32'd3);
        send_beat(2'b01, 2, 0, t + 64'd80_000);
        read_expect("stream_clear_result3", 8'h2C, 32'd0);
        read_expect("stream_clear_count", 8'h10, 32'd0);
        read_expect("stream_clear_status", 8'h14, 32'd0);
        check_all("stream_clear");

        // ---- reset pulse mid-window ----
        send_beat(2'b00, 0, 0, t + 64'd200_000);
        send_beat(2'b00, 0, 0, t + 64'd300_000);
        send_beat(2'b01, 2, 0, t + 64'd310_000);
        check_all("pre_reset");
        #2 rst_n = 0;
        #1;
        check("reset_pulse_led", 64'(led), 64'd0);
        check("reset_pulse_tready", 64'(s_tready), 64'd0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        @(negedge clk);
        read_expect("reset_pulse_enable", 8'h04, 32'd0);
        check_all("post_reset");
        send_beat(2'b11, 1, 1, t + 64'd400_000);
        read_expect("post_reset_discard", 8'h24, 32'd0);

        rd = 32'd0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
